// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature A/B/Z encoder emulator stepping toward a signed target
module quad_encoder_gen #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 16,
  parameter int CPR   = 2048
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic signed [WIDTH-1:0] i_target,
  input  logic [DIV_W-1:0]        i_period,
  input  logic                    i_clear,
  output logic                    o_a,
  output logic                    o_b,
  output logic                    o_z,
  output logic signed [WIDTH-1:0] o_pos,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int REV_W = $clog2(CPR);
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STEP
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DIV_W-1:0]        r_div;
  logic [DIV_W-1:0]        w_div_nxt;
  logic [REV_W-1:0]        r_rev_pos;
  logic [REV_W-1:0]        w_rev_nxt;
  logic signed [WIDTH-1:0] r_pos;
  logic signed [WIDTH-1:0] w_pos_nxt;
  logic                    r_a;
  logic                    r_b;
  logic                    r_z;
  logic                    r_done;
  logic                    w_a_nxt;
  logic                    w_b_nxt;
  logic                    w_z_nxt;
  logic                    w_done_nxt;
  logic [DIV_W-1:0]        w_eff_period;
  logic                    w_at_target;
  logic                    w_dir_fwd;

  // Periods 0 and 1 both give the minimum 2-clock edge spacing
  assign w_eff_period = (i_period <= DIV_W'(1)) ? DIV_W'(1) : i_period;
  assign w_at_target  = (r_pos == i_target);
  assign w_dir_fwd    = (i_target > r_pos);

  // Next-state, divider and edge generation; clear overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_pos_nxt   = r_pos;
    w_rev_nxt   = r_rev_pos;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_z_nxt     = r_z;
    w_done_nxt  = 1'b0;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_div_nxt   = w_eff_period;
      w_pos_nxt   = '0;
      w_rev_nxt   = '0;
      w_a_nxt     = 1'b0;
      w_b_nxt     = 1'b0;
      w_z_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable && !w_at_target) begin
            w_state_nxt = S_WAIT;
            w_div_nxt   = w_eff_period;
          end
        end
        S_WAIT: begin
          if (w_at_target) begin
            w_state_nxt = S_IDLE;
          end else if (i_enable) begin
            if (r_div <= DIV_W'(1)) begin
              w_state_nxt = S_STEP;
              w_div_nxt   = '0;
            end else begin
              w_div_nxt = r_div - DIV_W'(1);
            end
          end
        end
        S_STEP: begin
          if (w_at_target) begin
            w_state_nxt = S_IDLE;
          end else if (i_enable) begin
            if (w_dir_fwd) begin
              w_pos_nxt = r_pos + WIDTH'(1);
              w_rev_nxt = (r_rev_pos == REV_MAX) ? '0 : r_rev_pos + REV_W'(1);
            end else begin
              w_pos_nxt = r_pos - WIDTH'(1);
              w_rev_nxt = (r_rev_pos == '0) ? REV_MAX : r_rev_pos - REV_W'(1);
            end
            // Phase follows rev_pos[1:0] as a Gray code: 00,01,11,10
            w_a_nxt   = w_rev_nxt[1];
            w_b_nxt   = w_rev_nxt[1] ^ w_rev_nxt[0];
            w_z_nxt   = (w_rev_nxt == '0);
            w_div_nxt = w_eff_period;
            if (w_pos_nxt == i_target) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_pos     <= '0;
      r_rev_pos <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_z       <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_pos     <= w_pos_nxt;
      r_rev_pos <= w_rev_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_z       <= w_z_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_z    = r_z;
  assign o_pos  = r_pos;
  assign o_done = r_done;
  assign o_busy = i_enable && (r_pos != i_target);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - directed self-checking bench for quad_encoder_gen
module tb_quad_encoder_gen;

  localparam int W   = 16;
  localparam int DW  = 16;
  localparam int CPR = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                clear;
  logic signed [W-1:0] target;
  logic [DW-1:0]       period;
  logic                a;
  logic                b;
  logic                z;
  logic signed [W-1:0] pos;
  logic                busy;
  logic                done;

  int checks   = 0;
  int failures = 0;
  int dec_cnt  = 0;

  quad_encoder_gen #(.WIDTH(W), .DIV_W(DW), .CPR(CPR)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_target (target),
    .i_period (period),
    .i_clear  (clear),
    .o_a      (a),
    .o_b      (b),
    .o_z      (z),
    .o_pos    (pos),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] fwd_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] bwd_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Wait for n edges, checking spacing, pos, phase, index, done and a decoder count
  task automatic do_edges(input int n, input int dir, input int first_sp, input int sp);
    for (int e = 0; e < n; e++) begin
      int          old_pos;
      logic [1:0]  old_ab;
      logic [1:0]  new_ab;
      logic [1:0]  q;
      int          cnt;
      int          exp_p;
      old_pos = int'(pos);
      old_ab  = {a, b};
      cnt     = 0;
      do begin
        tick();
        cnt++;
        if (int'(pos) == old_pos) chk("done_between_edges", done, 0);
      end while (int'(pos) == old_pos && cnt < 40);
      chk("edge_spacing", cnt, (e == 0) ? first_sp : sp);
      exp_p = old_pos + dir;
      chk("pos", int'(pos), exp_p);
      q = exp_p[1:0];
      chk("ab_phase", {a, b}, {q[1], q[1] ^ q[0]});
      chk("z_index", z, (exp_p % CPR) == 0);
      new_ab = {a, b};
      if (new_ab == fwd_of(old_ab))      dec_cnt++;
      else if (new_ab == bwd_of(old_ab)) dec_cnt--;
      else                               dec_cnt += 1000;
      chk("decoder_cnt", dec_cnt, int'(pos));
      chk("done_at_edge", done, exp_p == int'(target));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    target = '0;
    period = '0;
    #3;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_z", z, 0);
    chk("rst_pos", int'(pos), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 1: forward move to 4 with period 3
    period = 16'd3;
    target = 16'sd4;
    enable = 1'b1;
    #1;
    chk("busy_start", busy, 1);
    do_edges(4, 1, 5, 4);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);

    // 2: backward to 0; pos 0 lands on index
    target = 16'sd0;
    do_edges(4, -1, 5, 4);

    // 3: index crossing forward then backward past 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    dec_cnt = 0;
    chk("clear_pos", int'(pos), 0);
    chk("clear_z", z, 0);
    period = 16'd1;
    target = 16'sd9;
    do_edges(9, 1, 3, 2);
    target = -16'sd1;
    do_edges(10, -1, 3, 2);

    // 4: reversal mid-move
    clear  = 1'b1;
    target = 16'sd100;
    tick();
    clear = 1'b0;
    dec_cnt = 0;
    do_edges(5, 1, 3, 2);
    target = 16'sd2;
    do_edges(3, -1, 2, 2);

    // 5: minimum period, then enable hold preserving the divider
    clear  = 1'b1;
    period = 16'd0;
    target = 16'sd3;
    tick();
    clear = 1'b0;
    dec_cnt = 0;
    do_edges(3, 1, 3, 2);
    period = 16'd5;
    target = 16'sd10;
    do_edges(1, 1, 7, 6);
    tick();
    tick();
    enable = 1'b0;
    repeat (10) tick();
    chk("hold_pos", int'(pos), 4);
    chk("hold_ab", {a, b}, 2'b00);
    chk("hold_busy", busy, 0);
    enable = 1'b1;
    do_edges(1, 1, 4, 6);

    // 6: clear colliding with STEP, then async reset mid-move
    clear  = 1'b1;
    period = 16'd1;
    target = 16'sd5;
    tick();
    clear = 1'b0;
    dec_cnt = 0;
    do_edges(2, 1, 3, 2);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_step_pos", int'(pos), 0);
    chk("clr_step_ab", {a, b}, 2'b00);
    chk("clr_step_z", z, 0);
    chk("clr_step_done", done, 0);
    dec_cnt = 0;
    do_edges(3, 1, 3, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", a, 0);
    chk("async_rst_b", b, 0);
    chk("async_rst_z", z, 0);
    chk("async_rst_pos", int'(pos), 0);
    chk("async_rst_done", done, 0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
